// File: rtl/vrased_reset_ctrl.sv
// Aggregates security-monitor violation requests into one stretched MCU reset request
// with sticky per-source cause flags; VRASED_RST_CNT_EN builds the saturating event counter.
module vrased_reset_ctrl #(
    parameter int NUM_SRC    = 4,
    parameter int RST_CYCLES = 16,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] viol_in,
    input  logic               cause_clr,
    output logic               puc_req,
    output logic [NUM_SRC-1:0] cause,
    output logic [CNT_W-1:0]   viol_cnt,
    output logic               busy
);

    localparam int SC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [SC_W-1:0] STRETCH_LOAD = SC_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE
    } state_e;

    state_e              state_q;
    logic [SC_W-1:0]     stretch_q;
    logic                puc_req_q;
    logic                busy_q;
    logic [NUM_SRC-1:0]  cause_q;
    logic                any_viol;

    assign any_viol = |viol_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stretch_q <= '0;
            puc_req_q <= 1'b0;
            busy_q    <= 1'b0;
            cause_q   <= '0;
        end else begin
            // Set beats clear for any bit whose source is active this cycle.
            cause_q <= (cause_q & ~{NUM_SRC{cause_clr}}) | viol_in;

            case (state_q)
                ST_IDLE: begin
                    if (any_viol) begin
                        state_q   <= ST_ASSERT;
                        stretch_q <= STRETCH_LOAD;
                        puc_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else begin
                        puc_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    busy_q <= 1'b1;
                    if (stretch_q == '0) begin
                        // HOLD with nothing pending is passed through in zero time so the
                        // pulse is exactly RST_CYCLES long and drops straight into RELEASE.
                        if (any_viol) begin
                            state_q   <= ST_HOLD;
                            puc_req_q <= 1'b1;
                        end else begin
                            state_q   <= ST_RELEASE;
                            puc_req_q <= 1'b0;
                        end
                    end else begin
                        stretch_q <= stretch_q - SC_W'(1);
                        puc_req_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    busy_q <= 1'b1;
                    if (any_viol) begin
                        puc_req_q <= 1'b1;
                    end else begin
                        state_q   <= ST_RELEASE;
                        puc_req_q <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (any_viol) begin
                        state_q   <= ST_ASSERT;
                        stretch_q <= STRETCH_LOAD;
                        puc_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q   <= ST_IDLE;
                        puc_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    puc_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign puc_req = puc_req_q;
    assign busy    = busy_q;
    assign cause   = cause_q;

`ifdef VRASED_RST_CNT_EN
    logic [CNT_W-1:0] viol_cnt_q;
    logic             new_event;

    // Only entries into ASSERT are events; violations seen mid-reset are not.
    assign new_event = any_viol && ((state_q == ST_IDLE) || (state_q == ST_RELEASE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_cnt_q <= '0;
        end else if (new_event && (viol_cnt_q != '1)) begin
            viol_cnt_q <= viol_cnt_q + CNT_W'(1);
        end
    end

    assign viol_cnt = viol_cnt_q;
`else
    assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Scoreboard bench for vrased_reset_ctrl: a default instance (RST_CYCLES=16, CNT_W=8)
// and a short-stretch, narrow-counter instance (RST_CYCLES=1, CNT_W=2).
module tb_vrased_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] viol_in;
    logic       cause_clr;
    logic       puc_req;
    logic [3:0] cause;
    logic [7:0] viol_cnt;
    logic       busy;

    logic [3:0] viol2;
    logic       clr2;
    logic       puc2;
    logic [3:0] cause2;
    logic [1:0] cnt2;
    logic       busy2;

    typedef struct {
        string      tag;
        logic       puc;
        logic       busy;
        logic [3:0] cause;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ev    = 0;
    int   ev2   = 0;

    vrased_reset_ctrl #(.NUM_SRC(4), .RST_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .viol_in(viol_in), .cause_clr(cause_clr),
        .puc_req(puc_req), .cause(cause), .viol_cnt(viol_cnt), .busy(busy)
    );

    vrased_reset_ctrl #(.NUM_SRC(4), .RST_CYCLES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .viol_in(viol2), .cause_clr(clr2),
        .puc_req(puc2), .cause(cause2), .viol_cnt(cnt2), .busy(busy2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cnt(int n, int w);
`ifdef VRASED_RST_CNT_EN
        int sat;
        sat = (1 << w) - 1;
        return (n > sat) ? 8'(sat) : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    function automatic exp_t mk(string tag, logic p, logic b, logic [3:0] c, logic [7:0] n);
        exp_t e;
        e.tag = tag; e.puc = p; e.busy = b; e.cause = c; e.cnt = n;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cause();
        cause_clr = 1'b1;
        clr2      = 1'b1;
        tick();
        cause_clr = 1'b0;
        clr2      = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        tick();
        tick();
        sb.push_back(mk("reset_dut", 1'b0, 1'b0, 4'b0000, 8'd0));
        sb.push_back(mk("reset_dut2", 1'b0, 1'b0, 4'b0000, 8'd0));
        e = sb.pop_front(); n_cmp++;
        if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
            n_bad++;
            $display("FAIL %s: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                     e.tag, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
        end
        e = sb.pop_front(); n_cmp++;
        if ({puc2, busy2, cause2, 6'd0, cnt2} !== {e.puc, e.busy, e.cause, e.cnt}) begin
            n_bad++;
            $display("FAIL %s: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                     e.tag, puc2, busy2, cause2, cnt2, e.puc, e.busy, e.cause, e.cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk("idle_after_reset", 1'b0, 1'b0, 4'b0000, exp_cnt(ev, 8)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                         e.tag, i, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_stretch();
        exp_t e;
        clear_cause();
        for (int i = 0; i <= 18; i++) begin
            viol_in = (i == 0) ? 4'b0001 : 4'b0000;
            if (i == 0) ev++;
            sb.push_back(mk("stretch", i <= 15, i <= 16, 4'b0001, exp_cnt(ev, 8)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                         e.tag, i, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        clear_cause();
        for (int i = 0; i <= 42; i++) begin
            viol_in = (i <= 39) ? 4'b0001 : 4'b0000;
            if (i == 0) ev++;
            sb.push_back(mk("hold", i <= 39, i <= 40, 4'b0001, exp_cnt(ev, 8)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                         e.tag, i, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_overlap();
        exp_t e;
        clear_cause();
        for (int i = 0; i <= 18; i++) begin
            viol_in = (i == 0) ? 4'b0001 : ((i == 5) ? 4'b0100 : 4'b0000);
            if (i == 0) ev++;
            sb.push_back(mk("overlap", i <= 15, i <= 16, (i < 5) ? 4'b0001 : 4'b0101, exp_cnt(ev, 8)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                         e.tag, i, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_clear_race();
        exp_t       e;
        logic [3:0] c;
        clear_cause();
        for (int i = 0; i <= 18; i++) begin
            viol_in   = (i == 0) ? 4'b0011 : ((i == 1) ? 4'b0010 : 4'b0000);
            cause_clr = (i == 1) || (i == 3);
            if (i == 0) ev++;
            c = (i == 0) ? 4'b0011 : ((i < 3) ? 4'b0010 : 4'b0000);
            sb.push_back(mk("clear_race", i <= 15, i <= 16, c, exp_cnt(ev, 8)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                         e.tag, i, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
            end
        end
        cause_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        clear_cause();
        for (int i = 0; i <= 35; i++) begin
            viol_in = ((i == 0) || (i == 17)) ? 4'b0001 : 4'b0000;
            if ((i == 0) || (i == 17)) ev++;
            sb.push_back(mk("back_to_back", (i <= 15) || ((i >= 17) && (i <= 32)), i <= 33,
                            4'b0001, exp_cnt(ev, 8)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                         e.tag, i, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        logic hit;
        for (int i = 0; i <= 10; i++) begin
            hit   = ((i % 2) == 0) && (i <= 8);
            viol2 = hit ? 4'b0001 : 4'b0000;
            if (hit) ev2++;
            sb.push_back(mk("saturate", hit, i <= 9, 4'b0001, exp_cnt(ev2, 2)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if ({puc2, busy2, cause2, 6'd0, cnt2} !== {e.puc, e.busy, e.cause, e.cnt}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                         e.tag, i, puc2, busy2, cause2, cnt2, e.puc, e.busy, e.cause, e.cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        clear_cause();
        for (int i = 0; i <= 24; i++) begin
            viol_in = 4'b0001;
            if (i == 0) ev++;
            sb.push_back(mk("into_hold", 1'b1, 1'b1, 4'b0001, exp_cnt(ev, 8)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                         e.tag, i, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
            end
        end
        #3;
        rst = 1'b1;
        ev  = 0;
        ev2 = 0;
        #1;
        sb.push_back(mk("async_rst_dut", 1'b0, 1'b0, 4'b0000, 8'd0));
        sb.push_back(mk("async_rst_dut2", 1'b0, 1'b0, 4'b0000, 8'd0));
        e = sb.pop_front(); n_cmp++;
        if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
            n_bad++;
            $display("FAIL %s: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                     e.tag, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
        end
        e = sb.pop_front(); n_cmp++;
        if ({puc2, busy2, cause2, 6'd0, cnt2} !== {e.puc, e.busy, e.cause, e.cnt}) begin
            n_bad++;
            $display("FAIL %s: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                     e.tag, puc2, busy2, cause2, cnt2, e.puc, e.busy, e.cause, e.cnt);
        end
        sb.push_back(mk("rst_held", 1'b0, 1'b0, 4'b0000, 8'd0));
        tick();
        e = sb.pop_front(); n_cmp++;
        if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
            n_bad++;
            $display("FAIL %s: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                     e.tag, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
        end
        #2;
        rst = 1'b0;
        for (int i = 0; i <= 17; i++) begin
            viol_in = (i == 0) ? 4'b0001 : 4'b0000;
            if (i == 0) ev++;
            sb.push_back(mk("rst_release", i <= 15, i <= 16, 4'b0001, exp_cnt(ev, 8)));
            tick();
            e = sb.pop_front(); n_cmp++;
            if ({puc_req, busy, cause, viol_cnt} !== {e.puc, e.busy, e.cause, e.cnt}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got puc=%b busy=%b cause=%b cnt=%0d, want puc=%b busy=%b cause=%b cnt=%0d",
                         e.tag, i, puc_req, busy, cause, viol_cnt, e.puc, e.busy, e.cause, e.cnt);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        viol_in   = 4'b0000;
        cause_clr = 1'b0;
        viol2     = 4'b0000;
        clr2      = 1'b0;
        test_reset();
        test_stretch();
        test_hold();
        test_overlap();
        test_clear_race();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vrased_reset_ctrl.md
# vrased_reset_ctrl

Downstream aggregator for the hardware security monitors (atomicity, key-access, DMA, stack-protection). Collects their level-sensitive violation/reset requests, generates a single stretched MCU reset request `puc_req`, and records which monitor(s) fired in a sticky cause register that software reads and clears after reboot. Sits between the monitor outputs and the core's reset input.

## Interface
- `NUM_SRC`, 4: number of violation sources; bit 0 is the atomicity monitor.
- `RST_CYCLES`, 16: minimum `puc_req` high time in cycles; legal range 1..256.
- `CNT_W`, 8: width of the violation event counter.

- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `viol_in` in NUM_SRC: level violation requests from the monitors; may stay high for many cycles.
- `cause_clr` in 1: single-cycle pulse that clears `cause` (software read-clear strobe).
- `puc_req` out 1: registered reset request to the core.
- `cause` out NUM_SRC: sticky per-source violation flags.
- `viol_cnt` out CNT_W: saturating count of violation events.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ASSERT, HOLD, RELEASE.
- IDLE: `puc_req`=0. If any `viol_in` bit is high, go to ASSERT, load the stretch counter with RST_CYCLES-1, and count one event.
- ASSERT: `puc_req`=1. Decrement the stretch counter each cycle. When the counter is 0, go to HOLD.
- HOLD: `puc_req`=1 while any `viol_in` bit is high. When all bits are low, go to RELEASE.
- RELEASE: `puc_req`=0 for exactly one cycle, then IDLE. If any `viol_in` bit is high in RELEASE, go directly to ASSERT; this counts as a new event.
- Cause flags:
  - Every cycle, `cause` <= (`cause` & ~{NUM_SRC{`cause_clr`}}) | `viol_in`.
  - When `cause_clr` and a `viol_in` bit are high in the same cycle, the set wins for that bit.
  - Flags are set in every state.
- Event counter:
  - Increments only on IDLE->ASSERT and RELEASE->ASSERT transitions, never per cycle.
  - Saturates at 2^CNT_W-1.
  - Cleared only by `rst`.
- A violation that arrives during ASSERT or HOLD updates `cause` only. It does not restart the stretch counter and is not counted.
- A source that holds its request until the core reaches the reset handler (the atomicity monitor does this) keeps the FSM in HOLD. `puc_req` therefore stays high until every source deasserts.

## Timing
- All outputs are registered. `viol_in` is sampled on the rising edge of `clk`.
- Latency: `viol_in` high before edge N gives `puc_req`=1, the `cause` bit set and `viol_cnt` incremented, all visible after edge N.
- `puc_req` minimum high time: exactly RST_CYCLES cycles when `viol_in` is low by the end of ASSERT. With RST_CYCLES=1, ASSERT lasts one cycle.
- `puc_req` falls on the edge after HOLD samples all-low `viol_in`. It stays low for at least one cycle (RELEASE) before any re-assertion.
- Asynchronous `rst`: state IDLE, `puc_req`=0, `cause`=0, `viol_cnt`=0, `busy`=0, stretch counter 0. All take effect immediately, including mid-ASSERT or mid-HOLD.
- Deasserting `rst` while `viol_in` is high enters ASSERT on the first clock edge.

## Configuration
- `VRASED_RST_CNT_EN` defined: the event counter is built and `viol_cnt` behaves as described above.
- Not defined: no counter flops are built, `viol_cnt` is tied to 0, and all other behaviour is identical.

## Test plan
- Stretch: pulse `viol_in`=4'b0001 for 1 cycle, RST_CYCLES=16 -> `puc_req` high exactly 16 cycles, then RELEASE and IDLE; `cause`=4'b0001; `viol_cnt`=1.
- Hold: keep `viol_in`[0] high for 40 cycles -> `puc_req` high 40 cycles, falls the cycle after `viol_in` drops; `viol_cnt`=1.
- Overlap: `viol_in`[0] at t0, `viol_in`[2] at t0+5 (1 cycle) -> `cause`=4'b0101, `viol_cnt`=1, `puc_req` high 16 cycles from t0.
- Clear race: `cause`=4'b0011; `cause_clr` together with `viol_in`=4'b0010 -> `cause`=4'b0010.
- Back-to-back: `viol_in` asserted in the RELEASE cycle -> `puc_req` low exactly 1 cycle, re-enters ASSERT, `viol_cnt`=2. With CNT_W=2, 5 events -> `viol_cnt`=3 (saturated).
- Async reset mid-HOLD: `rst` asserted between edges -> `puc_req`, `cause`, `viol_cnt` read 0 immediately. Without `VRASED_RST_CNT_EN`, `viol_cnt` stays 0 throughout every scenario.
